// File: rtl/keypad_matrix_emulator.sv
// Key-side model of a 4x4 keypad: plays each requested key as press bounce, hold,
// release bounce and gap, pulling the matching Row low while its Col is strobed.
module keypad_matrix_emulator #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned BOUNCE_CYCLES = 50_000,
  parameter int unsigned BOUNCE_TOGGLE = 5_000,
  parameter int unsigned HOLD_CYCLES   = 10_000_000,
  parameter int unsigned GAP_CYCLES    = 1_000_000
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, BNC_P, HOLD, BNC_R, GAP} state_e;

  localparam logic [CNT_W-1:0] BNC_LAST  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOG_LAST  = CNT_W'(BOUNCE_TOGGLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_BNC   = (BOUNCE_CYCLES != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tcnt_q, tcnt_d;
  logic             tog_q, tog_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       col_m_q, col_s_q;
  logic [3:0]       row_q, row_d;
  logic             rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;
  logic             contact, in_bnc;
  logic [1:0]       csel, rsel;

  // Returns {c, r} for a key; Col/Row bit indices are the inverted values (3-c, 3-r).
  function automatic logic [3:0] key_map(input logic [3:0] k);
    case (k)
      4'h1: key_map = {2'd0, 2'd0};
      4'h4: key_map = {2'd0, 2'd1};
      4'h7: key_map = {2'd0, 2'd2};
      4'h0: key_map = {2'd0, 2'd3};
      4'h2: key_map = {2'd1, 2'd0};
      4'h5: key_map = {2'd1, 2'd1};
      4'h8: key_map = {2'd1, 2'd2};
      4'hF: key_map = {2'd1, 2'd3};
      4'h3: key_map = {2'd2, 2'd0};
      4'h6: key_map = {2'd2, 2'd1};
      4'h9: key_map = {2'd2, 2'd2};
      4'hE: key_map = {2'd2, 2'd3};
      4'hA: key_map = {2'd3, 2'd0};
      4'hB: key_map = {2'd3, 2'd1};
      4'hC: key_map = {2'd3, 2'd2};
      default: key_map = {2'd3, 2'd3};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tcnt_d  = tcnt_q;
    tog_d   = tog_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (key_valid && rdy_q) begin
          code_d  = key_code;
          state_d = HAS_BNC ? BNC_P : HOLD;
        end
      end
      BNC_P:   if (cnt_q == BNC_LAST)  state_d = HOLD;
      HOLD:    if (cnt_q == HOLD_LAST) state_d = HAS_BNC ? BNC_R : GAP;
      BNC_R:   if (cnt_q == BNC_LAST)  state_d = GAP;
      GAP:     if (cnt_q == GAP_LAST)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_bnc = (state_q == BNC_P) || (state_q == BNC_R);
    if (state_d != state_q) begin
      cnt_d  = '0;
      tcnt_d = '0;
      tog_d  = 1'b1;
    end else if (in_bnc) begin
      if (tcnt_q == TOG_LAST) begin
        tcnt_d = '0;
        tog_d  = ~tog_q;
      end else begin
        tcnt_d = tcnt_q + CNT_W'(1);
      end
    end

    contact      = (state_q == HOLD) || (in_bnc && tog_q);
    {csel, rsel} = ~key_map(code_q);
    row_d        = 4'hF;
    row_d[rsel]  = ~(contact && !col_s_q[csel]);

    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_q == GAP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      tog_q   <= 1'b0;
      code_q  <= '0;
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
      row_q   <= 4'hF;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      tog_q   <= tog_d;
      code_q  <= code_d;
      col_m_q <= Col;
      col_s_q <= col_m_q;
      row_q   <= row_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_ready = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign Row       = row_q;

endmodule
